// File: rtl/float_mul_arbiter.sv
// Two-channel round-robin front end for a shared fixed-latency float multiplier.
// Tracks issue tags to route results back and counts overflow/underflow events.
module float_mul_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [23:0] req_a_0,
    input  logic [23:0] req_b_0,
    input  logic [23:0] req_a_1,
    input  logic [23:0] req_b_1,
    output logic [23:0] mul_a,
    output logic [23:0] mul_b,
    output logic        mul_valid,
    input  logic [23:0] mul_out,
    input  logic        mul_underflow,
    input  logic        mul_overflow,
    output logic [23:0] rsp_data,
    output logic        rsp_underflow,
    output logic        rsp_overflow,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        cnt_clr,
    output logic [7:0]  ovf_cnt,
    output logic [7:0]  unf_cnt,
    output logic        busy
);

    localparam int D = LATENCY + 1;

    logic          last_q, last_d;
    logic [23:0]   ma_q, ma_d, mb_q, mb_d;
    logic          mv_q, mv_d;
    logic [D-1:0]  tv_q, tv_d, tc_q, tc_d;
    logic [23:0]   rd_q, rd_d;
    logic          ru_q, ru_d, ro_q, ro_d;
    logic          rv0_q, rv0_d, rv1_q, rv1_d;
    logic [7:0]    oc_q, oc_d, uc_q, uc_d;
    logic          gnt0, gnt1, xfer, rsp_hit;

    // last_q = 1 means channel 1 was granted last, so channel 0 wins a tie.
    always_comb begin
        gnt0 = req_valid_0 & (~req_valid_1 | last_q);
        gnt1 = req_valid_1 & (~req_valid_0 | ~last_q);
        xfer = gnt0 | gnt1;
    end

    always_comb begin
        last_d = last_q;
        ma_d   = ma_q;
        mb_d   = mb_q;
        if (xfer) begin
            last_d = gnt1;
            ma_d   = gnt1 ? req_a_1 : req_a_0;
            mb_d   = gnt1 ? req_b_1 : req_b_0;
        end
        mv_d = xfer;
        tv_d = {tv_q[D-2:0], xfer};
        tc_d = {tc_q[D-2:0], gnt1};
    end

    always_comb begin
        rsp_hit = tv_q[D-1];
        rd_d    = rd_q;
        ru_d    = ru_q;
        ro_d    = ro_q;
        rv0_d   = rsp_hit & ~tc_q[D-1];
        rv1_d   = rsp_hit & tc_q[D-1];
        oc_d    = oc_q;
        uc_d    = uc_q;
        if (rsp_hit) begin
            rd_d = mul_out;
            ru_d = mul_underflow;
            ro_d = mul_overflow;
            if (mul_overflow && oc_q != 8'hFF) begin
                oc_d = oc_q + 8'd1;
            end
            if (mul_underflow && uc_q != 8'hFF) begin
                uc_d = uc_q + 8'd1;
            end
        end
        if (cnt_clr) begin
            oc_d = 8'd0;
            uc_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
            ma_q   <= '0;
            mb_q   <= '0;
            mv_q   <= 1'b0;
            tv_q   <= '0;
            tc_q   <= '0;
            rd_q   <= '0;
            ru_q   <= 1'b0;
            ro_q   <= 1'b0;
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            oc_q   <= '0;
            uc_q   <= '0;
        end else begin
            last_q <= last_d;
            ma_q   <= ma_d;
            mb_q   <= mb_d;
            mv_q   <= mv_d;
            tv_q   <= tv_d;
            tc_q   <= tc_d;
            rd_q   <= rd_d;
            ru_q   <= ru_d;
            ro_q   <= ro_d;
            rv0_q  <= rv0_d;
            rv1_q  <= rv1_d;
            oc_q   <= oc_d;
            uc_q   <= uc_d;
        end
    end

    assign req_ready_0   = gnt0;
    assign req_ready_1   = gnt1;
    assign mul_a         = ma_q;
    assign mul_b         = mb_q;
    assign mul_valid     = mv_q;
    assign rsp_data      = rd_q;
    assign rsp_underflow = ru_q;
    assign rsp_overflow  = ro_q;
    assign rsp_valid_0   = rv0_q;
    assign rsp_valid_1   = rv1_q;
    assign ovf_cnt       = oc_q;
    assign unf_cnt       = uc_q;
    assign busy          = mv_q | (|tv_q);

endmodule

// File: doc/float_mul_arbiter.md
FLOAT_MUL_ARBITER -- requirements
Module: float_mul_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, legal range 1..8: fixed cycle latency of the shared float multiplier from operand registration to valid result.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid_0 / req_valid_1  input  1 each  channel request valid.
REQ-005 SHALL have ports req_ready_0 / req_ready_1  output  1 each  channel grant/accept.
REQ-006 SHALL have ports req_a_0, req_b_0, req_a_1, req_b_1  input  24 each  operands; format: sign[23], exponent[22:16] bias 63, mantissa[15:0].
REQ-007 SHALL have ports mul_a, mul_b  output  24 each  registered operands to the shared multiplier.
REQ-008 SHALL have port mul_valid  output  1  registered issue strobe.
REQ-009 SHALL have ports mul_out  input  24, mul_underflow  input  1, mul_overflow  input  1  multiplier result and flags.
REQ-010 SHALL have ports rsp_data  output  24, rsp_underflow  output  1, rsp_overflow  output  1  registered response shared by both channels.
REQ-011 SHALL have ports rsp_valid_0 / rsp_valid_1  output  1 each  one-cycle response strobe per channel.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of both flag counters.
REQ-013 SHALL have ports ovf_cnt, unf_cnt  output  8 each  saturating overflow/underflow event counters.
REQ-014 SHALL have port busy  output  1  high while any issue is in flight.

Function
REQ-015 Arbitration SHALL be combinational from req_valid_x and last_grant: one valid -> grant it; both valid -> grant channel != last_grant; none -> no grant.
REQ-016 req_ready_x SHALL equal grant_x; transfer occurs on the edge where req_valid_x && req_ready_x; last_grant updates only on transfer.
REQ-017 Requesters SHALL hold operands stable while valid and not ready; no requirement on req_valid deassertion.
REQ-018 On transfer at edge E0, mul_a/mul_b SHALL take the granted operands and mul_valid SHALL be 1 for the cycle after E0; without transfer mul_valid SHALL be 0 and mul_a/mul_b hold.
REQ-019 A tag pipeline of LATENCY+1 stages (valid bit + channel bit) SHALL shift every cycle, loading the transfer at E0.
REQ-020 At edge E0+LATENCY+1 the block SHALL register mul_out and flags into rsp_*, and assert rsp_valid of the tagged channel only, for exactly one cycle.
REQ-021 Throughput SHALL be one transfer per cycle; back-to-back responses SHALL keep issue order.
REQ-022 Responses SHALL have no backpressure; rsp_data/flags hold their last value when no rsp_valid is high.
REQ-023 ovf_cnt/unf_cnt SHALL increment by 1 per response carrying the respective flag, saturating at 255.
REQ-024 cnt_clr SHALL zero both counters next edge; clr and increment in the same cycle -> 0.
REQ-025 busy SHALL be OR of mul_valid and all tag-pipeline valid bits.

Reset
REQ-026 rst low SHALL immediately force: req_ready_x dependent on last_grant=1 (channel 0 wins first tie), mul_a=mul_b=0, mul_valid=0, all tags invalid, rsp_data=0, flags=0, rsp_valid_x=0, counters=0, busy=0.
REQ-027 Reset mid-operation SHALL discard all in-flight results; no rsp_valid after release for pre-reset transfers.

Verification
REQ-028 Single ch0 request a=24'h469040 (200.125), b=24'h3D8000 (0.375), LATENCY=2 -> rsp_valid_0 exactly 3 cycles after accept edge, rsp_data=24'h452C30 (model), rsp_valid_1 stays 0.
REQ-029 Both channels valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses return in same order with correct channel strobes.
REQ-030 Ch1 request a=24'h7F0000, b=24'h400000 with model overflow -> rsp_overflow=1, rsp_valid_1, ovf_cnt=1.
REQ-031 300 overflow responses -> ovf_cnt=255; cnt_clr coincident with an overflow response -> ovf_cnt=0.
REQ-032 Assert rst low with 3 transfers in flight -> all outputs zero immediately, busy=0, no rsp_valid after release.
REQ-033 Request held valid while other channel granted -> operands unchanged, accepted next cycle, single response.
